// File: rtl/read_block.sv
// DMA read-side engine: fetches an unaligned byte region with aligned word reads
// and repacks it into a lane-0-aligned, strobed valid/ready output stream.
module read_block #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] address,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       out_data,
  output logic [3:0]        out_strb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int NW_W = LEN_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] curr_q, curr_d;
  logic [NW_W-1:0]   nwords_q, nwords_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        off_q, off_d;
  logic              first_q, first_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [63:0]       buf_q, buf_d;

  logic [LEN_W+1:0]  span;
  logic [NW_W-1:0]   newWords;
  logic [1:0]        startLane;
  logic [2:0]        availBytes;
  logic [2:0]        takeBytes;
  logic [2:0]        shiftBytes;
  logic [63:0]       capWord;
  logic [63:0]       capMask;
  logic [63:0]       capBuf;

  // Word count covering [address, address+length) depends only on the start
  // offset within the first word, so no wide address arithmetic is needed.
  always_comb begin
    span     = (LEN_W+2)'(length) + (LEN_W+2)'(address[1:0]) + (LEN_W+2)'(3);
    newWords = NW_W'(span >> 2);
  end

  // Buffer bytes above cnt are kept zero, so new lanes can simply be OR-ed in.
  always_comb begin
    startLane  = first_q ? off_q : 2'd0;
    availBytes = 3'd4 - {1'b0, startLane};
    if (int'(rem_q) < int'(availBytes)) begin
      takeBytes = 3'(rem_q);
    end else begin
      takeBytes = availBytes;
    end
    capWord    = {32'd0, mem_rd_data >> {startLane, 3'b000}};
    capMask    = ~(64'hFFFF_FFFF_FFFF_FFFF << {takeBytes, 3'b000});
    capBuf     = buf_q | ((capWord & capMask) << {cnt_q, 3'b000});
    shiftBytes = (cnt_q >= 3'd4) ? 3'd4 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      curr_q   <= '0;
      nwords_q <= '0;
      rem_q    <= '0;
      off_q    <= '0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      curr_q   <= curr_d;
      nwords_q <= nwords_d;
      rem_q    <= rem_d;
      off_q    <= off_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    curr_d      = curr_q;
    nwords_d    = nwords_q;
    rem_d       = rem_q;
    off_d       = off_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_strb    = '0;
    done        = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (trigger) begin
          off_d    = address[1:0];
          rem_d    = length;
          curr_d   = {address[ADDR_W-1:2], 2'b00};
          nwords_d = newWords;
          first_d  = 1'b1;
          cnt_d    = '0;
          buf_d    = '0;
          state_d  = (length == '0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = curr_q;
        curr_d      = curr_q + ADDR_W'(4);
        nwords_d    = nwords_q - NW_W'(1);
        state_d     = CAPTURE;
      end

      CAPTURE: begin
        buf_d   = capBuf;
        cnt_d   = cnt_q + takeBytes;
        rem_d   = rem_q - LEN_W'(takeBytes);
        first_d = 1'b0;
        if ((cnt_d >= 3'd4) || (nwords_q == '0)) begin
          state_d = EMIT;
        end else begin
          state_d = ISSUE;
        end
      end

      // Another read is only issued once cnt has dropped to 3 or less.
      EMIT: begin
        out_valid = 1'b1;
        out_data  = buf_q[31:0];
        out_strb  = (cnt_q >= 3'd4) ? 4'b1111 : ((4'd1 << cnt_q) - 4'd1);
        if (out_ready) begin
          buf_d = buf_q >> {shiftBytes, 3'b000};
          cnt_d = cnt_q - shiftBytes;
          if (nwords_q != '0) begin
            state_d = ISSUE;
          end else if (cnt_d != '0) begin
            state_d = EMIT;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_read_block.sv
// Testbench for read_block: directed vector table, stall/reset sequences and
// randomized transfers checked against a byte-level reference model.
module tb_read_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [4:0]  length;
  logic [31:0] address;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int testsRun = 0;
  int failures = 0;
  int cyc = 0;
  int trigCyc = 0;

  logic [31:0] readQ[$];
  int          readCyc[$];
  logic [31:0] beatData[$];
  logic [3:0]  beatStrb[$];
  int          beatCyc[$];
  int          doneCnt = 0;
  int          doneCyc = -1;
  int          busyCnt = 0;
  int          validCnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  len;
    int          nReads;
    logic [31:0] firstRead;
    int          nBeats;
    logic [31:0] firstData;
    logic [3:0]  lastStrb;
    logic [31:0] lastData;
  } vec_t;

  vec_t vecs[5];

  read_block #(.ADDR_W(32), .LEN_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .length(length),
    .address(address),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_data(out_data),
    .out_strb(out_strb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns byte A[7:0] at address A, one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= {8'(mem_rd_addr + 32'd3), 8'(mem_rd_addr + 32'd2),
                      8'(mem_rd_addr + 32'd1), 8'(mem_rd_addr)};
    end else begin
      mem_rd_data <= 32'hA5A5_A5A5;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      readQ.push_back(mem_rd_addr);
      readCyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      beatData.push_back(out_data);
      beatStrb.push_back(out_strb);
      beatCyc.push_back(cyc);
    end
    if (done) begin
      doneCnt = doneCnt + 1;
      doneCyc = cyc;
    end
    if (busy) busyCnt = busyCnt + 1;
    if (out_valid) validCnt = validCnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] strbMask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun = testsRun + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    readQ.delete();
    readCyc.delete();
    beatData.delete();
    beatStrb.delete();
    beatCyc.delete();
    doneCnt = 0;
    doneCyc = -1;
    busyCnt = 0;
    validCnt = 0;
  endtask

  task automatic waitDone(input bit randReady);
    for (int i = 0; i < 400 && doneCnt == 0; i++) begin
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [4:0] len, input bit randReady);
    clearLogs();
    @(posedge clk); #1;
    address = addr;
    length  = len;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    trigCyc = cyc;
    waitDone(randReady);
  endtask

  // Reference: walk the region byte by byte; each byte's word is a read,
  // every four consecutive bytes form one beat.
  task automatic checkTransfer(input string tag, input logic [31:0] addr, input logic [4:0] len);
    logic [31:0] expReads[$];
    logic [31:0] expData[$];
    logic [3:0]  expStrb[$];
    logic [31:0] a, w, d;
    logic [3:0]  s;
    d = '0;
    s = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 32'(i);
      w = a & 32'hFFFF_FFFC;
      if (expReads.size() == 0 || expReads[expReads.size()-1] != w) expReads.push_back(w);
      d[8*(i%4) +: 8] = a[7:0];
      s[i%4] = 1'b1;
      if ((i % 4) == 3 || i == int'(len) - 1) begin
        expData.push_back(d);
        expStrb.push_back(s);
        d = '0;
        s = '0;
      end
    end
    checkOutput({tag, " readCount"}, 64'(readQ.size()), 64'(expReads.size()));
    for (int i = 0; i < expReads.size() && i < readQ.size(); i++) begin
      checkOutput($sformatf("%s readAddr[%0d]", tag, i), 64'(readQ[i]), 64'(expReads[i]));
    end
    checkOutput({tag, " beatCount"}, 64'(beatData.size()), 64'(expData.size()));
    for (int i = 0; i < expData.size() && i < beatData.size(); i++) begin
      checkOutput($sformatf("%s beatStrb[%0d]", tag, i), 64'(beatStrb[i]), 64'(expStrb[i]));
      checkOutput($sformatf("%s beatData[%0d]", tag, i),
                  64'(beatData[i] & strbMask(expStrb[i])), 64'(expData[i]));
    end
    checkOutput({tag, " doneCount"}, 64'(doneCnt), 64'd1);
    if (len == 5'd0) begin
      checkOutput({tag, " doneLatency"}, 64'(doneCyc), 64'(trigCyc));
      checkOutput({tag, " busyCycles"}, 64'(busyCnt), 64'd1);
      checkOutput({tag, " noValid"}, 64'(validCnt), 64'd0);
    end else begin
      if (readCyc.size() > 0) checkOutput({tag, " firstReadLatency"}, 64'(readCyc[0]), 64'(trigCyc));
      if (beatCyc.size() > 0) checkOutput({tag, " doneAfterBeat"}, 64'(doneCyc), 64'(beatCyc[beatCyc.size()-1] + 1));
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 5'd8,  2, 32'h0000_1000, 2, 32'h0302_0100, 4'b1111, 32'h0706_0504};
    vecs[1] = '{32'h0000_1002, 5'd6,  2, 32'h0000_1000, 2, 32'h0504_0302, 4'b0011, 32'h0000_0706};
    vecs[2] = '{32'h0000_2003, 5'd31, 9, 32'h0000_2000, 8, 32'h0605_0403, 4'b0111, 32'h0021_201F};
    vecs[3] = '{32'h0000_3001, 5'd0,  0, 32'h0000_0000, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFE, 5'd4,  2, 32'hFFFF_FFFC, 1, 32'h0100_FFFE, 4'b1111, 32'h0100_FFFE};

    rst       = 1'b1;
    trigger   = 1'b0;
    length    = '0;
    address   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset mem_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset out_strb", 64'(out_strb), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].len, 1'b0);
      checkTransfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len);
      checkOutput($sformatf("vec%0d nReads", v), 64'(readQ.size()), 64'(vecs[v].nReads));
      checkOutput($sformatf("vec%0d nBeats", v), 64'(beatData.size()), 64'(vecs[v].nBeats));
      if (vecs[v].nReads > 0 && readQ.size() > 0)
        checkOutput($sformatf("vec%0d firstRead", v), 64'(readQ[0]), 64'(vecs[v].firstRead));
      if (vecs[v].nBeats > 0 && beatData.size() > 0) begin
        checkOutput($sformatf("vec%0d firstData", v), 64'(beatData[0]), 64'(vecs[v].firstData));
        checkOutput($sformatf("vec%0d lastStrb", v), 64'(beatStrb[beatStrb.size()-1]), 64'(vecs[v].lastStrb));
        checkOutput($sformatf("vec%0d lastData", v),
                    64'(beatData[beatData.size()-1] & strbMask(beatStrb[beatStrb.size()-1])),
                    64'(vecs[v].lastData));
      end
    end

    // Stall the first beat for five cycles and re-pulse trigger meanwhile.
    clearLogs();
    @(posedge clk); #1;
    address   = 32'h0000_1002;
    length    = 5'd6;
    trigger   = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    trigger = 1'b0;
    trigCyc = cyc;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("stall valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall data[%0d]", k), 64'(out_data), 64'h0504_0302);
      checkOutput($sformatf("stall strb[%0d]", k), 64'(out_strb), 64'hF);
      checkOutput($sformatf("stall valid[%0d]", k), 64'(out_valid), 64'd1);
      if (k == 2) begin
        address = 32'h0000_5000;
        length  = 5'd3;
        trigger = 1'b1;
      end else begin
        trigger = 1'b0;
      end
      @(posedge clk); #1;
    end
    trigger = 1'b0;
    waitDone(1'b0);
    checkTransfer("stall", 32'h0000_1002, 5'd6);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("stall noExtraReads", 64'(readQ.size()), 64'd2);
    checkOutput("stall idleAfter", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a transfer.
    clearLogs();
    @(posedge clk); #1;
    address = 32'h0000_1000;
    length  = 5'd16;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("midReset busyBefore", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midReset mem_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("midReset mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    checkOutput("midReset out_valid", 64'(out_valid), 64'd0);
    checkOutput("midReset out_data", 64'(out_data), 64'd0);
    checkOutput("midReset out_strb", 64'(out_strb), 64'd0);
    checkOutput("midReset busy", 64'(busy), 64'd0);
    checkOutput("midReset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("midReset noDone", 64'(doneCnt), 64'd0);
    applyStimulus(32'h0000_1002, 5'd6, 1'b0);
    checkTransfer("afterReset", 32'h0000_1002, 5'd6);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] ra;
      logic [4:0]  rl;
      ra = $urandom;
      rl = 5'($urandom_range(0, 31));
      applyStimulus(ra, rl, 1'b1);
      checkTransfer($sformatf("rand%0d a=%08h l=%0d", r, ra, rl), ra, rl);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/read_block.md
Name: read_block

Overview:
- DMA read-side engine, the source-side counterpart of the destination write engine.
- On trigger, it reads a 0–31 byte region at an arbitrary (unaligned) source address using aligned 32-bit word reads.
- It strips the leading and trailing bytes that fall outside the region and repacks the payload into a byte-0-aligned output stream with per-byte strobes.
- It sits between the memory read port and the DMA data path (valid/ready).

Parameters:
ADDR_W, 32, address width; word size fixed at 4 bytes.
LEN_W, 5, transfer length width in bytes (maximum length 2^LEN_W-1).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
trigger  in  1  start pulse, sampled only in IDLE
length  in  LEN_W  number of bytes to read
address  in  ADDR_W  unaligned source byte address
mem_rd_en  out  1  word read strobe, one cycle per word
mem_rd_addr  out  ADDR_W  word-aligned read address (bits [1:0]=0)
mem_rd_data  in  32  read data, valid the cycle after mem_rd_en=1; little-endian byte lanes
out_data  out  32  realigned payload; first source byte in lane 0
out_strb  out  4  valid byte lanes of out_data
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat when out_valid & out_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (async, any state): state=IDLE; mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_strb=0, done=0, busy=0; byte buffer and counters cleared. Any in-flight transfer is abandoned; no done pulse.
- Trigger latches the following values:
  - off = address[1:0]
  - rem = length
  - curr = {address[ADDR_W-1:2],2'b00}
  - nwords = ((address+length-1)>>2) - (address>>2) + 1
  - Address arithmetic is mod 2^ADDR_W; curr wraps from 0xFFFFFFFC to 0.
- Internal buffer: 8 bytes, with count cnt of 0..7.
- State machine:
  - IDLE:
    - trigger=1 and length=0: go to DONE.
    - trigger=1 and length>0: go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Drive mem_rd_en=1 and mem_rd_addr=curr for exactly one cycle.
    - curr+=4; nwords-=1.
    - Go to CAPTURE.
  - CAPTURE:
    - Sample mem_rd_data.
    - Take lanes from (first word ? off : 0) upward, limited to rem bytes.
    - Append these bytes to the buffer above the existing cnt bytes; update cnt and rem.
    - If cnt>=4 or nwords=0: go to EMIT. Otherwise go to ISSUE.
  - EMIT:
    - out_valid=1; out_data = buffer bytes 0..3.
    - out_strb = 4'b1111 if cnt>=4, else (1<<cnt)-1.
    - Beat accepted (out_ready=1): shift the buffer down by min(cnt,4) bytes and reduce cnt by the same amount. Then:
      - nwords>0: go to ISSUE.
      - cnt>0: stay in EMIT.
      - Otherwise go to DONE.
    - out_ready=0: hold out_data, out_strb and out_valid stable.
  - DONE: done=1 for one cycle, then go to IDLE.
- trigger while busy=1 is ignored; inputs are latched only in IDLE.
- Beat count: ceil(length/4); only the final beat may have a partial strobe.
- Read count: nwords reads, each address issued once and in ascending order.
- At most one read is outstanding at a time. The buffer never exceeds 7 bytes, because a read is only issued when cnt<=3.
- Latency: the first mem_rd_en occurs in the cycle after trigger is sampled. done follows the last accepted beat by one cycle. For length=0, done occurs the cycle after trigger, with no reads and no beats.

Test Plan:
Memory model: byte at address A = A[7:0].
1. address=0x1000, length=8, out_ready=1
   - Required: reads 0x1000, 0x1004.
   - Required: beats 0x03020100/1111 and 0x07060504/1111.
   - Required: done 1 cycle after the second beat.
2. address=0x1002, length=6
   - Required: reads 0x1000, 0x1004.
   - Required: beats 0x05040302/1111 then 0x....0706/0011.
   - Required: exactly 2 mem_rd_en pulses.
3. address=0x2003, length=31
   - Required: 9 reads, 0x2000..0x2020.
   - Required: 8 beats; first 0x06050403, last strb 0111 with lanes 0x21,0x20,0x1F.
4. length=0, address=0x3001
   - Required: no mem_rd_en and no out_valid; done pulses the cycle after trigger; busy high for 1 cycle.
5. Case 2 repeated with out_ready held low 5 cycles on beat 1, and trigger re-pulsed mid-transfer
   - Required: out_data/out_strb stable while stalled.
   - Required: no extra reads; the second trigger is ignored.
6. address=0xFFFFFFFE, length=4: reads 0xFFFFFFFC then 0x00000000, one beat with strb 1111. Separately, assert rst mid-transfer: all outputs 0 immediately, no done, and the next trigger runs normally.
